// File: rtl/oled_spi_if.sv
// SPI pin bundle between an OLED controller (master) and the display-side receiver (slave).
// CS is active low; SCLK idles high.
interface oled_spi_if;
  logic SCLK;
  logic SDIN;
  logic DC;
  logic CS;

  modport master (output SCLK, SDIN, DC, CS);
  modport slave  (input  SCLK, SDIN, DC, CS);
endinterface

// File: rtl/oled_spi_rx.sv
// Oversampling SPI slave and SSD1306-subset command decoder.
// It tracks the display flags and the page/column pointer, and emits frame-memory writes.
module oled_spi_rx #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [7:0]  CONTRAST_RST = 8'h7F
) (
  input  logic          clk,
  input  logic          rst,
  oled_spi_if.slave     spi,
  output logic          mem_we_o,
  output logic [8:0]    mem_addr_o,
  output logic [7:0]    mem_wdata_o,
  output logic          cmd_valid_o,
  output logic [7:0]    cmd_byte_o,
  output logic          disp_on_o,
  output logic          disp_full_o,
  output logic [7:0]    contrast_o,
  output logic          charge_pump_o,
  output logic          seg_remap_o,
  output logic          com_flip_o,
  output logic          partial_err_o
);

  typedef enum logic [2:0] {
    ST_CMD, ST_ARG_PG0, ST_ARG_PG1, ST_ARG_CONTRAST, ST_ARG_PUMP, ST_ARG_SKIP
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sdin_sync_q, dc_sync_q, cs_sync_q;
  logic       sclk_prev_q, cs_prev_q;
  logic [6:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       byte_vld_q, byte_dc_q, partial_err_q;
  logic [7:0] byte_q;

  logic sclk_s, sdin_s, dc_s, cs_s, sclk_rise, shift_en;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdin_s    = sdin_sync_q[SYNC_STAGES-1];
  assign dc_s      = dc_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  // The 8th edge still counts when CS rises in that same synced cycle.
  assign shift_en  = sclk_rise & (~cs_s | (~cs_prev_q & (bit_cnt_q == 3'd7)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q   <= '1;
      sdin_sync_q   <= '0;
      dc_sync_q     <= '0;
      cs_sync_q     <= '1;
      sclk_prev_q   <= 1'b1;
      cs_prev_q     <= 1'b1;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      byte_vld_q    <= 1'b0;
      byte_dc_q     <= 1'b0;
      byte_q        <= '0;
      partial_err_q <= 1'b0;
    end else begin
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
      sdin_sync_q   <= {sdin_sync_q[SYNC_STAGES-2:0], spi.SDIN};
      dc_sync_q     <= {dc_sync_q[SYNC_STAGES-2:0],   spi.DC};
      cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0],   spi.CS};
      sclk_prev_q   <= sclk_s;
      cs_prev_q     <= cs_s;
      byte_vld_q    <= 1'b0;
      partial_err_q <= 1'b0;
      if (shift_en) begin
        shift_q   <= {shift_q[5:0], sdin_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_vld_q <= 1'b1;
          byte_q     <= {shift_q, sdin_s};
          byte_dc_q  <= dc_s;
        end
      end else if (cs_s) begin
        bit_cnt_q     <= '0;
        partial_err_q <= (bit_cnt_q != 3'd0);
      end
    end
  end

  state_e     state_q, state_d;
  logic [1:0] page_q, page_d;
  logic [6:0] col_q, col_d;
  logic       mem_we_q, mem_we_d, cmd_valid_q, cmd_valid_d;
  logic [8:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d, cmd_byte_q, cmd_byte_d, contrast_q, contrast_d;
  logic       disp_on_q, disp_on_d, disp_full_q, disp_full_d, pump_q, pump_d;
  logic       remap_q, remap_d, flip_q, flip_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CMD;
      page_q      <= '0;
      col_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= '0;
      contrast_q  <= CONTRAST_RST;
      disp_on_q   <= 1'b0;
      disp_full_q <= 1'b0;
      pump_q      <= 1'b0;
      remap_q     <= 1'b0;
      flip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      col_q       <= col_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      contrast_q  <= contrast_d;
      disp_on_q   <= disp_on_d;
      disp_full_q <= disp_full_d;
      pump_q      <= pump_d;
      remap_q     <= remap_d;
      flip_q      <= flip_d;
    end
  end

  // Data bytes never move the decoder, whatever state it is in.
  always_comb begin
    state_d = state_q;
    if (byte_vld_q && !byte_dc_q) begin
      unique case (state_q)
        ST_CMD: begin
          case (byte_q)
            8'h22:                                    state_d = ST_ARG_PG0;
            8'h81:                                    state_d = ST_ARG_CONTRAST;
            8'h8D:                                    state_d = ST_ARG_PUMP;
            8'hD9, 8'hDA, 8'hD5, 8'hA8, 8'hD3, 8'h20: state_d = ST_ARG_SKIP;
            default:                                  state_d = ST_CMD;
          endcase
        end
        ST_ARG_PG0: state_d = ST_ARG_PG1;
        default:    state_d = ST_CMD;
      endcase
    end
  end

  always_comb begin
    page_d      = page_q;
    col_d       = col_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    contrast_d  = contrast_q;
    disp_on_d   = disp_on_q;
    disp_full_d = disp_full_q;
    pump_d      = pump_q;
    remap_d     = remap_q;
    flip_d      = flip_q;
    if (byte_vld_q && byte_dc_q) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = {page_q, col_q};
      mem_wdata_d = byte_q;
      col_d       = col_q + 7'd1;
    end else if (byte_vld_q) begin
      cmd_valid_d = 1'b1;
      cmd_byte_d  = byte_q;
      case (state_q)
        ST_CMD: begin
          if (byte_q[7:4] == 4'h0)      col_d = {col_q[6:4], byte_q[3:0]};
          else if (byte_q[7:4] == 4'h1) col_d = {byte_q[2:0], col_q[3:0]};
          case (byte_q)
            8'hAE: disp_on_d   = 1'b0;
            8'hAF: disp_on_d   = 1'b1;
            8'hA4: disp_full_d = 1'b0;
            8'hA5: disp_full_d = 1'b1;
            8'hA0: remap_d     = 1'b0;
            8'hA1: remap_d     = 1'b1;
            8'hC0: flip_d      = 1'b0;
            8'hC8: flip_d      = 1'b1;
            default: ;
          endcase
        end
        ST_ARG_PG0: begin
          page_d = byte_q[1:0];
          col_d  = '0;
        end
        ST_ARG_CONTRAST: contrast_d = byte_q;
        ST_ARG_PUMP:     pump_d     = byte_q[2];
        default: ;
      endcase
    end
  end

  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign cmd_byte_o    = cmd_byte_q;
  assign disp_on_o     = disp_on_q;
  assign disp_full_o   = disp_full_q;
  assign contrast_o    = contrast_q;
  assign charge_pump_o = pump_q;
  assign seg_remap_o   = remap_q;
  assign com_flip_o    = flip_q;
  assign partial_err_o = partial_err_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Randomized scoreboard bench for oled_spi_rx.
// A byte-level display model predicts each strobe, and a monitor pops and compares the predictions.
module tb_oled_spi_rx;
  localparam int HP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  oled_spi_if spi_if ();

  logic       mem_we, cmd_valid, disp_on, disp_full, charge_pump, seg_remap, com_flip, partial_err;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata, cmd_byte, contrast;

  oled_spi_rx #(.SYNC_STAGES(2), .CONTRAST_RST(8'h7F)) dut (
    .clk(clk), .rst(rst), .spi(spi_if),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .cmd_valid_o(cmd_valid), .cmd_byte_o(cmd_byte),
    .disp_on_o(disp_on), .disp_full_o(disp_full), .contrast_o(contrast),
    .charge_pump_o(charge_pump), .seg_remap_o(seg_remap), .com_flip_o(com_flip),
    .partial_err_o(partial_err)
  );

  typedef struct {
    int         kind;      // 0 write, 1 command, 2 partial
    int         addr;
    int         val;
    int         contrast;
    int         flags;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  // Display model: pending argument kind, pointer and flags.
  int  m_arg;   // 0 none, 1 page start, 2 page end, 3 contrast, 4 pump, 5 skip
  int  m_page, m_col, m_contrast;
  bit  m_on, m_full, m_pump, m_remap, m_flip;

  function automatic int m_flags();
    return {27'd0, m_on, m_full, m_pump, m_remap, m_flip};
  endfunction

  task automatic model_reset();
    m_arg = 0; m_page = 0; m_col = 0; m_contrast = 8'h7F;
    m_on = 0; m_full = 0; m_pump = 0; m_remap = 0; m_flip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit dc);
    ev_t e;
    int  v;
    v = int'(b);
    if (dc) begin
      e.kind = 0; e.addr = m_page * 128 + m_col; e.val = v;
      m_col = (m_col + 1) % 128;
    end else begin
      if (m_arg == 1) begin
        m_page = v % 4; m_col = 0; m_arg = 2;
      end else if (m_arg != 0) begin
        if (m_arg == 3) m_contrast = v;
        if (m_arg == 4) m_pump = b[2];
        m_arg = 0;
      end else if (v < 16) begin
        m_col = (m_col / 16) * 16 + v;
      end else if (v < 32) begin
        m_col = (v % 8) * 16 + m_col % 16;
      end else begin
        case (v)
          'h22: m_arg = 1;
          'h81: m_arg = 3;
          'h8D: m_arg = 4;
          'hD9, 'hDA, 'hD5, 'hA8, 'hD3, 'h20: m_arg = 5;
          'hAE: m_on = 0;    'hAF: m_on = 1;
          'hA4: m_full = 0;  'hA5: m_full = 1;
          'hA0: m_remap = 0; 'hA1: m_remap = 1;
          'hC0: m_flip = 0;  'hC8: m_flip = 1;
          default: ;
        endcase
      end
      e.kind = 1; e.val = v; e.addr = 0;
    end
    e.contrast = m_contrast;
    e.flags    = m_flags();
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (mem_we || cmd_valid) begin
        if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          e = exp_q.pop_front();
          if (mem_we) begin
            chk("wr_kind", 0, e.kind);
            chk("wr_addr", int'(mem_addr), e.addr);
            chk("wr_data", int'(mem_wdata), e.val);
            chk("wr_no_cmd", int'(cmd_valid), 0);
          end else begin
            chk("cmd_kind", 1, e.kind);
            chk("cmd_byte", int'(cmd_byte), e.val);
            chk("cmd_flags", {27'd0, disp_on, disp_full, charge_pump, seg_remap, com_flip}, e.flags);
            chk("cmd_contrast", int'(contrast), e.contrast);
          end
        end
      end
      if (partial_err) begin
        if (exp_q.size() == 0) chk("unexpected_partial", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("partial_kind", 2, e.kind);
        end
      end
    end
  end

  task automatic spi_bit(input bit b, input bit dc, input bit cs_up);
    spi_if.SCLK = 1'b0; spi_if.SDIN = b; spi_if.DC = dc;
    repeat (HP) @(posedge clk);
    spi_if.SCLK = 1'b1;
    if (cs_up) spi_if.CS = 1'b1;
    repeat (HP) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit dc, input bit cs_up_last);
    model_byte(b, dc);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], dc, cs_up_last && (i == 0));
  endtask

  task automatic cs_cycle();
    spi_if.CS = 1'b1;
    repeat (2 * HP) @(posedge clk);
    spi_if.CS = 1'b0;
    repeat (2 * HP) @(posedge clk);
  endtask

  task automatic send_partial(input int nbits);
    ev_t e;
    e.kind = 2; e.addr = 0; e.val = nbits; e.contrast = 0; e.flags = 0;
    exp_q.push_back(e);
    for (int i = 0; i < nbits; i++) spi_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    cs_cycle();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_we"},       int'(mem_we), 0);
    chk({tag, "_cmdv"},     int'(cmd_valid), 0);
    chk({tag, "_perr"},     int'(partial_err), 0);
    chk({tag, "_addr"},     int'(mem_addr), 0);
    chk({tag, "_wdata"},    int'(mem_wdata), 0);
    chk({tag, "_cmdbyte"},  int'(cmd_byte), 0);
    chk({tag, "_flags"},    {27'd0, disp_on, disp_full, charge_pump, seg_remap, com_flip}, 0);
    chk({tag, "_contrast"}, int'(contrast), 'h7F);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  int cmd_list [20] = '{'h22, 'h81, 'h8D, 'hD9, 'hDA, 'hD5, 'hA8, 'hD3, 'h20, 'hAE,
                        'hAF, 'hA4, 'hA5, 'hA0, 'hA1, 'hC0, 'hC8, 'h05, 'h13, 'h3F};

  initial begin
    logic [7:0] rb;
    bit         rdc;
    spi_if.SCLK = 1'b1; spi_if.SDIN = 1'b0; spi_if.DC = 1'b0; spi_if.CS = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;
    repeat (4) @(posedge clk);
    spi_if.CS = 1'b0;
    repeat (2 * HP) @(posedge clk);

    send_byte(8'hAF, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0); send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0); send_byte(8'h10, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b0); send_byte(8'hC3, 1'b1, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0); send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h0F, 1'b0, 1'b0); send_byte(8'h17, 1'b0, 1'b0);
    send_byte(8'h0F, 1'b0, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0); send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h81, 1'b0, 1'b0); send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'h8D, 1'b0, 1'b0); send_byte(8'h14, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0); send_byte(8'hC8, 1'b0, 1'b0);
    // Data during an argument state must not consume the argument.
    send_byte(8'h81, 1'b0, 1'b0); send_byte(8'h77, 1'b1, 1'b0); send_byte(8'h40, 1'b0, 1'b0);
    send_partial(5);
    send_byte(8'h81, 1'b1, 1'b0);
    // CS rising together with the 8th edge still completes the byte.
    send_byte(8'hA1, 1'b0, 1'b1);
    repeat (2 * HP) @(posedge clk);
    spi_if.CS = 1'b0;
    repeat (2 * HP) @(posedge clk);
    cs_cycle();

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) send_partial($urandom_range(1, 7));
      rdc = 1'($urandom_range(0, 1));
      if (!rdc && $urandom_range(0, 2) != 0) rb = 8'(cmd_list[$urandom_range(0, 19)]);
      else rb = 8'($urandom_range(0, 255));
      send_byte(rb, rdc, 1'b0);
    end
    drain("drain_main");
    chk("final_contrast", int'(contrast), m_contrast);
    chk("final_flags", {27'd0, disp_on, disp_full, charge_pump, seg_remap, com_flip}, m_flags());

    for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2 * HP) @(posedge clk);
    send_byte(8'hAF, 1'b0, 1'b0);
    send_byte(8'hAE, 1'b0, 1'b0);
    send_byte(8'h9E, 1'b1, 1'b0);
    drain("drain_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
